regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_read_port.sv | 44 ++++
 rtl/regfile_scoreboard.sv | 68 ++++++
 tb/tb_regfile_scoreboard.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helper for the register file with scoreboard.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;

  // Index width for n entries; never returns less than 1.
  function automatic int addr_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: data select, optional write bypass (REGFILE_BYPASS_EN), busy flag.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    addr,
  input  logic [XLEN-1:0]  regs [NREGS],
  input  logic [NREGS-1:0] pending_nxt,
`ifdef REGFILE_BYPASS_EN
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [XLEN-1:0]  wr_data,
`endif
  output logic [XLEN-1:0]  data,
  output logic             busy
);

  logic [XLEN-1:0] rd;

  always_comb begin
    rd = regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (we && (wr_addr == addr)) rd = wr_data;
`endif
    // x0 reads as zero regardless of array contents or bypass
    if (addr == '0) rd = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      busy <= 1'b0;
    end else begin
      data <= rd;
      busy <= pending_nxt[addr];
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits and NREAD registered read ports.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEFAULT,
  parameter int  NREGS = NREGS_DEFAULT,
  parameter int  NREAD = 2,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  res_en,
  input  logic [AW-1:0]         res_addr,
  input  logic                  flush,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  output logic [NREGS-1:0]      pending
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending_nxt;

  // Order matters: write clears, a same-cycle reservation re-sets, flush wins over both.
  always_comb begin
    pending_nxt = pending;
    if (we && (wr_addr != '0)) pending_nxt[wr_addr] = 1'b0;
    if (res_en && (res_addr != '0)) pending_nxt[res_addr] = 1'b1;
    if (flush) pending_nxt = '0;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NREGS; n++) regs[n] <= '0;
      pending <= '0;
    end else begin
      if (we && (wr_addr != '0)) regs[wr_addr] <= wr_data;
      pending <= pending_nxt;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    regfile_read_port #(
      .XLEN (XLEN),
      .NREGS(NREGS),
      .AW   (AW)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .addr       (rs_addr[i*AW +: AW]),
      .regs       (regs),
      .pending_nxt(pending_nxt),
`ifdef REGFILE_BYPASS_EN
      .we         (we),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
`endif
      .data       (rs_data[i*XLEN +: XLEN]),
      .busy       (rs_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard (default parameters, two read ports).
module tb_regfile_scoreboard;

  logic         clk;
  logic         rst;
  logic         we;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         res_en;
  logic [4:0]   res_addr;
  logic         flush;
  logic [9:0]   rs_addr;
  logic [127:0] rs_data;
  logic [1:0]   rs_busy;
  logic [31:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_scoreboard dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .res_en  (res_en),
    .res_addr(res_addr),
    .flush   (flush),
    .rs_addr (rs_addr),
    .rs_data (rs_data),
    .rs_busy (rs_busy),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        b0;
    logic        b1;
    logic [31:0] pend;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample #1 after the edge.
  task automatic cyc(input logic w, input logic [4:0] wa, input logic [63:0] wd,
                     input logic r, input logic [4:0] ra, input logic f,
                     input logic [4:0] a0, input logic [4:0] a1);
    we = w; wr_addr = wa; wr_data = wd;
    res_en = r; res_addr = ra; flush = f;
    rs_addr = {a1, a0};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, a0, a1);
  endtask

  logic [63:0] exp_byp;

  initial begin
    rst = 1'b1;
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);
    check("reset_pending", {32'd0, pending}, 64'd0);
    check("reset_data0", rs_data[63:0], 64'd0);
    check("reset_busy", {62'd0, rs_busy}, 64'd0);
    rst = 1'b0;

    //          we  wa     wd                      re  ra     fl  r0     r1     d0         d1         b0 b1 pend
    vecs[0] = '{1'b1, 5'd1,  64'h11,               1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  64'h0,  64'h0,  1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 5'd2,  64'h22,               1'b1, 5'd3,  1'b0, 5'd1,  5'd0,  64'h11, 64'h0,  1'b0, 1'b0, 32'h8};
    vecs[2] = '{1'b0, 5'd0,  64'h0,                1'b1, 5'd4,  1'b0, 5'd2,  5'd3,  64'h22, 64'h0,  1'b0, 1'b1, 32'h18};
    vecs[3] = '{1'b1, 5'd3,  64'h33,               1'b0, 5'd0,  1'b0, 5'd4,  5'd1,  64'h0,  64'h11, 1'b1, 1'b0, 32'h10};
    vecs[4] = '{1'b0, 5'd0,  64'h0,                1'b0, 5'd0,  1'b0, 5'd3,  5'd3,  64'h33, 64'h33, 1'b0, 1'b0, 32'h10};
    vecs[5] = '{1'b0, 5'd0,  64'h0,                1'b1, 5'd5,  1'b1, 5'd4,  5'd5,  64'h0,  64'h0,  1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 5'd0,  64'hDEAD_BEEF,        1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  64'h0,  64'h0,  1'b0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31, 1'b0, 5'd0, 5'd2, 64'h0,  64'h22, 1'b0, 1'b0, 32'h8000_0000};
    vecs[8] = '{1'b0, 5'd0,  64'h0,                1'b0, 5'd0,  1'b0, 5'd31, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000};

    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].fl, vecs[i].r0, vecs[i].r1);
      check($sformatf("vec%0d_d0", i), rs_data[63:0], vecs[i].d0);
      check($sformatf("vec%0d_d1", i), rs_data[127:64], vecs[i].d1);
      check($sformatf("vec%0d_busy", i), {62'd0, rs_busy}, {62'd0, vecs[i].b1, vecs[i].b0});
      check($sformatf("vec%0d_pending", i), {32'd0, pending}, {32'd0, vecs[i].pend});
    end

    // x0 stays zero and never pending
    cyc(1'b1, 5'd0, 64'hDEAD_BEEF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    check("x0_data", rs_data[63:0], 64'd0);
    check("x0_pending0", {63'd0, pending[0]}, 64'd0);
    check("x0_busy", {63'd0, rs_busy[0]}, 64'd0);

    // reserve, observe busy, write clears it
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 1'b0, 5'd0, 5'd0);
    idle(5'd5, 5'd0);
    check("sb_busy_set", {63'd0, rs_busy[0]}, 64'd1);
    cyc(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    idle(5'd5, 5'd0);
    check("sb_busy_clr", {63'd0, rs_busy[0]}, 64'd0);
    check("sb_data", rs_data[63:0], 64'h1234);

    // same-cycle reserve and write to x7: new producer keeps it pending
    cyc(1'b1, 5'd7, 64'h55, 1'b1, 5'd7, 1'b0, 5'd0, 5'd0);
    check("coll_pending7", {63'd0, pending[7]}, 64'd1);
    idle(5'd0, 5'd7);
    check("coll_data", rs_data[127:64], 64'h55);
    check("coll_busy", {63'd0, rs_busy[1]}, 64'd1);

    // write-to-read in same cycle
    cyc(1'b1, 5'd3, 64'hA, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    cyc(1'b1, 5'd3, 64'hB, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
`ifdef REGFILE_BYPASS_EN
    exp_byp = 64'hB;
`else
    exp_byp = 64'hA;
`endif
    check("bypass_data", rs_data[63:0], exp_byp);
    idle(5'd3, 5'd0);
    check("bypass_after", rs_data[63:0], 64'hB);

    // flush overrides a same-cycle reservation
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 1'b0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
    check("flush_pre", {32'd0, pending}, 64'h0000_0000_8000_0286);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 1'b1, 5'd4, 5'd9);
    check("flush_pending", {32'd0, pending}, 64'd0);
    check("flush_busy", {62'd0, rs_busy}, 64'd0);

    // reset wins over a same-cycle write and reservation
    rst = 1'b1;
    cyc(1'b1, 5'd6, 64'h66, 1'b1, 5'd6, 1'b0, 5'd5, 5'd31);
    rst = 1'b0;
    check("rst_pending", {32'd0, pending}, 64'd0);
    check("rst_rsdata", rs_data[63:0] | rs_data[127:64], 64'd0);
    idle(5'd5, 5'd6);
    check("rst_x5", rs_data[63:0], 64'd0);
    check("rst_x6", rs_data[127:64], 64'd0);
    idle(5'd31, 5'd3);
    check("rst_x31_x3", rs_data[63:0] | rs_data[127:64], 64'd0);
    check("rst_busy", {62'd0, rs_busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
